// File: rtl/eq_serial_if.sv
// Serial operand link between a bit-pair sender and the eq_serial checker.
interface eq_serial_if #(
  parameter int CNT_W = 3
) ();
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             eq;
  logic [CNT_W-1:0] mismatch_idx;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, eq, mismatch_idx
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, eq, mismatch_idx
  );
endinterface

// File: rtl/eq_serial.sv
// Bit-serial WIDTH-bit equality checker, LSB first, XNOR cell into a running AND.
// Optional EQ_SERIAL_EARLY_ABORT_EN: finish the word on its first mismatching bit.
module eq_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  eq_serial_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmp  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             eq_q, eq_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic             bit_ok;
  logic             acc_nx;
  logic             last_bit;
  logic [CNT_W-1:0] first_nx;

  assign bit_ok   = bus.a_bit ~^ bus.b_bit;
  assign acc_nx   = acc_q & bit_ok;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // Index of the earliest mismatch including the bit arriving now; 0 if none so far.
  assign first_nx = seen_q ? first_q : (bit_ok ? '0 : cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    first_d = first_q;
    eq_d    = eq_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StCmp;
          cnt_d   = '0;
          acc_d   = 1'b1;
          seen_d  = 1'b0;
          first_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StCmp: begin
        if (bus.bit_valid) begin
          acc_d = acc_nx;
          cnt_d = cnt_q + 1'b1;
          if (!bit_ok && !seen_q) begin
            seen_d  = 1'b1;
            first_d = cnt_q;
          end
`ifdef EQ_SERIAL_EARLY_ABORT_EN
          if (last_bit || !bit_ok) begin
`else
          if (last_bit) begin
`endif
            state_d = StDone;
            eq_d    = acc_nx;
            idx_d   = first_nx;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= 1'b1;
      seen_q  <= 1'b0;
      first_q <= '0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      first_q <= first_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy         = (state_q == StCmp);
  assign bus.done         = (state_q == StDone);
  assign bus.eq           = eq_q;
  assign bus.mismatch_idx = idx_q;

endmodule
